// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard interface: the decode stage drives the instruction
// description and pipeline handshake and receives forwarding selects and lock.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [REG_W-1:0] rs1_addr;
    logic [REG_W-1:0] rs2_addr;
    logic             uses_rs1;
    logic             uses_rs2;
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
    logic             issue;
    logic             advance;
    logic             flush;
    logic [1:0]       rs1_sel;
    logic [1:0]       rs2_sel;
    logic             lock;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, rs1_addr, rs2_addr, uses_rs1, uses_rs2,
        output rd, rd_we, is_load, issue, advance, flush,
        input  rs1_sel, rs2_sel, lock, stall_count
    );

    modport slave (
        input  id_valid, rs1_addr, rs2_addr, uses_rs1, uses_rs2,
        input  rd, rd_we, is_load, issue, advance, flush,
        output rs1_sel, rs2_sel, lock, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for decode. A three-slot scoreboard tracks the
// destination registers of instructions in execute (S0), execute output (S1)
// and memory output (S2). Selects encode: 0=REG, 1=ALU, 2=EXE, 3=MEM.
module hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic        aclk,
    input  logic        areset,
    hazard_ctrl_if.slave hif
);
    localparam int SLOTS = 3;
    localparam int NSRC  = 2;

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_EXE = 2'd2;
    localparam logic [1:0] SEL_MEM = 2'd3;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } slot_t;

    slot_t [SLOTS-1:0] sb;
    slot_t             s0_in;

    logic [NSRC-1:0][REG_W-1:0] src_addr;
    logic [NSRC-1:0]            src_use;
    logic [NSRC-1:0][1:0]       src_sel;
    logic [NSRC-1:0]            src_hitld;
    logic [CNT_W-1:0]           stall_cnt;

    // Entry presented to S0; x0 is never tracked and a flush kills it outright
    always_comb begin
        s0_in    = '0;
        s0_in.v  = hif.issue & hif.rd_we & (hif.rd != '0) & ~hif.flush;
        s0_in.rd = hif.rd;
        s0_in.ld = hif.is_load;
    end

    // Scoreboard shift on advance; flush alone still squashes S0
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            sb <= '0;
        else if (hif.advance)
            sb <= {sb[1], sb[0], s0_in};
        else if (hif.flush)
            sb[0].v <= 1'b0;
    end

    assign src_addr = {hif.rs2_addr, hif.rs1_addr};
    assign src_use  = {hif.uses_rs2, hif.uses_rs1};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [SLOTS-1:0] hit;
        logic [1:0]       sel;
        logic             hitld;

        // Per-slot address match for this source
        always_comb begin
            hit = '0;
            for (int s = 0; s < SLOTS; s++)
                hit[s] = sb[s].v & (sb[s].rd == src_addr[i]);
        end

        // Youngest producer wins; only S0/S1 loads can't be forwarded yet
        always_comb begin
            sel   = SEL_REG;
            hitld = 1'b0;
            if (src_use[i] && (src_addr[i] != '0)) begin
                if (hit[0]) begin
                    sel   = SEL_ALU;
                    hitld = sb[0].ld;
                end else if (hit[1]) begin
                    sel   = SEL_EXE;
                    hitld = sb[1].ld;
                end else if (hit[2]) begin
                    sel   = SEL_MEM;
                end
            end
        end

        assign src_sel[i]   = sel;
        assign src_hitld[i] = hitld;
    end

    assign hif.rs1_sel = src_sel[0];
    assign hif.rs2_sel = src_sel[1];
    assign hif.lock    = hif.id_valid & (|src_hitld);

    // Saturating count of locked cycles
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            stall_cnt <= '0;
        else if (hif.lock && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign hif.stall_count = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences, a queue-based model
// of in-flight producers checked every negedge, plus literal spot checks.
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam logic [1:0] REG = 2'd0, ALU = 2'd1, EXE = 2'd2, MEM = 2'd3;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .aclk   (aclk),
        .areset (areset),
        .hif    (hif)
    );

    always #5 aclk = ~aclk;

    // Decode fires only when not locked and the pipe is moving
    assign hif.issue = hif.id_valid & ~hif.lock & hif.advance;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of in-flight producers, youngest first
    typedef struct {
        bit             v;
        bit [REG_W-1:0] rd;
        bit             ld;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;

    function automatic int youngest(input logic [REG_W-1:0] a);
        for (int i = 0; i < q.size(); i++)
            if (q[i].v && q[i].rd == a) return i;
        return -1;
    endfunction

    function automatic logic [1:0] m_sel(input logic [REG_W-1:0] a, input logic u);
        int k;
        if (a == 0 || !u) return REG;
        k = youngest(a);
        case (k)
            0:       return ALU;
            1:       return EXE;
            2:       return MEM;
            default: return REG;
        endcase
    endfunction

    function automatic bit m_dep(input logic [REG_W-1:0] a, input logic u);
        int k;
        if (a == 0 || !u) return 1'b0;
        k = youngest(a);
        if (k < 0 || k > 1) return 1'b0;
        return q[k].ld;
    endfunction

    function automatic bit m_lock();
        return hif.id_valid && (m_dep(hif.rs1_addr, hif.uses_rs1) || m_dep(hif.rs2_addr, hif.uses_rs2));
    endfunction

    always @(posedge aclk or posedge areset) begin : model
        ent_t e;
        if (areset) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (m_lock()) m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
            if (hif.advance) begin
                e.v  = hif.issue && hif.rd_we && hif.rd != 0 && !hif.flush;
                e.rd = hif.rd;
                e.ld = hif.is_load;
                q.push_front(e);
                if (q.size() > 3) void'(q.pop_back());
            end else if (hif.flush && q.size() > 0) begin
                q[0].v = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge aclk) begin
        if (!done) begin
            check("m_rs1_sel", hif.rs1_sel, m_sel(hif.rs1_addr, hif.uses_rs1));
            check("m_rs2_sel", hif.rs2_sel, m_sel(hif.rs2_addr, hif.uses_rs2));
            check("m_lock", hif.lock, m_lock());
            check("m_stall_count", hif.stall_count, m_cnt);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic nop();
        hif.id_valid = 1'b0; hif.rs1_addr = '0; hif.rs2_addr = '0;
        hif.uses_rs1 = 1'b0; hif.uses_rs2 = 1'b0; hif.rd = '0;
        hif.rd_we = 1'b0; hif.is_load = 1'b0; hif.advance = 1'b1; hif.flush = 1'b0;
    endtask

    task automatic op(input logic [REG_W-1:0] rd_, input logic [REG_W-1:0] r1,
                      input logic [REG_W-1:0] r2, input logic ld, input logic fl);
        hif.id_valid = 1'b1; hif.rs1_addr = r1; hif.rs2_addr = r2;
        hif.uses_rs1 = 1'b1; hif.uses_rs2 = 1'b1; hif.rd = rd_;
        hif.rd_we = 1'b1; hif.is_load = ld; hif.advance = 1'b1; hif.flush = fl;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0] gap_exp [4];
        gap_exp[0] = ALU; gap_exp[1] = EXE; gap_exp[2] = MEM; gap_exp[3] = REG;

        nop();
        areset = 1'b1;
        repeat (2) tick();
        sample();
        check("rst_cnt", hif.stall_count, 0);
        check("rst_lock", hif.lock, 0);
        check("rst_rs1", hif.rs1_sel, REG);
        areset = 1'b0;
        tick();

        // Forwarding distance: 0..3 independent instructions in between
        for (int gap = 0; gap < 4; gap++) begin
            op(5, 1, 2, 0, 0); tick();
            for (int j = 0; j < gap; j++) begin op(12, 1, 2, 0, 0); tick(); end
            op(6, 5, 5, 0, 0);
            sample();
            check($sformatf("chain%0d_rs1", gap), hif.rs1_sel, gap_exp[gap]);
            check($sformatf("chain%0d_rs2", gap), hif.rs2_sel, gap_exp[gap]);
            tick(); drain();
        end

        // Load-use at distance 1: two lock cycles, then MEM
        op(7, 1, 2, 1, 0); tick();
        op(8, 7, 0, 0, 0);
        sample(); check("lu_lock1", hif.lock, 1); tick();
        sample(); check("lu_lock2", hif.lock, 1); tick();
        sample();
        check("lu_lock_drop", hif.lock, 0);
        check("lu_rs1", hif.rs1_sel, MEM);
        check("lu_rs2", hif.rs2_sel, REG);
        check("lu_cnt", hif.stall_count, 2);
        tick(); drain();

        // Youngest producer wins
        op(3, 1, 2, 0, 0); tick();
        op(3, 1, 2, 0, 0); tick();
        op(4, 3, 3, 0, 0);
        sample();
        check("prio_rs1", hif.rs1_sel, ALU);
        check("prio_rs2", hif.rs2_sel, ALU);
        tick(); drain();

        // x0 is never a producer, even as a load target
        op(0, 1, 2, 1, 0); tick();
        op(9, 0, 0, 0, 0);
        sample();
        check("x0_rs1", hif.rs1_sel, REG);
        check("x0_rs2", hif.rs2_sel, REG);
        check("x0_lock", hif.lock, 0);
        tick(); drain();

        // Flush squashes a simultaneously issued load
        op(10, 1, 2, 1, 1); tick();
        op(11, 10, 0, 0, 0);
        sample();
        check("flush_lock", hif.lock, 0);
        check("flush_rs1", hif.rs1_sel, REG);
        tick(); drain();

        // Hold: advance low keeps the scoreboard frozen
        op(13, 1, 2, 0, 0); tick();
        hif.id_valid = 1'b0; hif.advance = 1'b0;
        hif.rs1_addr = 13; hif.rs2_addr = 13; hif.rd = 14;
        for (int j = 0; j < 5; j++) begin
            sample();
            check($sformatf("hold%0d_rs1", j), hif.rs1_sel, ALU);
            tick();
        end
        hif.advance = 1'b1; tick();
        hif.advance = 1'b0;
        sample();
        check("hold_shift_rs2", hif.rs2_sel, EXE);
        tick(); drain();

        // Saturation: lock held 20 cycles with the pipe stalled
        op(15, 1, 2, 1, 0); tick();
        op(16, 15, 0, 0, 0); hif.advance = 1'b0;
        repeat (20) tick();
        sample();
        check("sat_cnt", hif.stall_count, MAXC);
        check("sat_lock", hif.lock, 1);
        tick(); drain();

        // Asynchronous reset mid-stream with slots full
        op(17, 1, 2, 0, 0); tick();
        op(18, 1, 2, 1, 0); tick();
        op(19, 1, 2, 0, 0); tick();
        op(20, 19, 18, 0, 0); hif.advance = 1'b0;
        sample();
        check("pre_rst_rs1", hif.rs1_sel, ALU);
        check("pre_rst_lock", hif.lock, 1);
        tick();
        areset = 1'b1;
        #1;
        check("arst_cnt", hif.stall_count, 0);
        check("arst_rs1", hif.rs1_sel, REG);
        check("arst_rs2", hif.rs2_sel, REG);
        check("arst_lock", hif.lock, 0);
        repeat (3) tick();
        areset = 1'b0;
        sample();
        check("post_rst_rs1", hif.rs1_sel, REG);
        check("post_rst_lock", hif.lock, 0);
        tick();

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the decode stage. Keeps a three-slot scoreboard of destination registers for instructions already issued past decode, in the execute, execute-output and memory-output positions. From that scoreboard it drives the decode stage's rs1_sel/rs2_sel forwarding selects and its lock input. It inserts load-use stalls and counts stall cycles for performance monitoring.

Parameters:
CNT_W, 32, width of the stall-cycle counter
REG_W, 5, register address width (matches core::addr_t)

Ports:
aclk  input  1  clock, rising edge
areset  input  1  asynchronous, active-high reset
id_valid  input  1  decode holds a valid instruction (decode source.tvalid)
rs1_addr  input  REG_W  decode source register 1 address
rs2_addr  input  REG_W  decode source register 2 address
uses_rs1  input  1  decoded instruction reads rs1
uses_rs2  input  1  decoded instruction reads rs2
rd  input  REG_W  decoded destination register
rd_we  input  1  decoded instruction writes rd
is_load  input  1  decoded instruction is a load
issue  input  1  decode handshake fired this cycle (source.tvalid & source.tready)
advance  input  1  pipeline past decode moves this cycle (sink.tready)
flush  input  1  squash the instruction in the execute slot (taken branch/jump)
rs1_sel  output  2  core::rs_t forwarding select for rs1
rs2_sel  output  2  core::rs_t forwarding select for rs2
lock  output  1  stall decode (feeds decode lock)
stall_count  output  CNT_W  saturating count of lock cycles

Behaviour:
- Scoreboard slots S0 (execute, result on alu_data), S1 (execute output, exe_data) and S2 (memory output, mem_data). Each slot holds v, rd and ld.
- Reset (async, areset=1): all slot v=0, stall_count=0. Outputs during and after reset: rs1_sel=rs2_sel=core::REG, lock=0.
- Reset mid-operation clears all slots immediately. No state survives.
- Update at posedge aclk when advance=1:
  - S2<=S1, S1<=S0.
  - S0 loads {v=issue & rd_we & (rd!=0), rd, ld=is_load}. If issue=0, S0 loads a bubble (v=0).
- When advance=0: all slots hold.
- flush=1 at posedge: S0.v<=0, overriding any load into S0, including a simultaneous issue. The S1 and S2 shifts still occur if advance=1.
- Selects (combinational, evaluated per source, shown for rs1):
  - rs1_addr==0 or uses_rs1=0 -> core::REG.
  - Else first match in priority order S0 -> core::ALU, S1 -> core::EXE, S2 -> core::MEM, none -> core::REG.
  - The youngest producer always wins.
- lock (combinational) = id_valid & ((uses_rs1 & hitld1) | (uses_rs2 & hitld2)).
  - hitldN: the highest-priority matching slot for rsN is S0 or S1 with ld=1, and rsN!=0.
  - A load in S2 is forwarded (core::MEM) with no lock.
- lock takes effect in the same cycle. Decode must hold source.tready low, so issue=0 while lock=1 and the bubble enters S0 on advance.
- A load-use at distance 1 therefore locks for 2 advancing cycles; at distance 2 it locks for 1.
- stall_count: +1 on every posedge with lock=1. It saturates at all ones and never wraps.
- x0 is never tracked: rd==0 with rd_we=1 gives v=0.

Test Plan:
- Reset: assert areset for 3 cycles mid-stream with slots full -> stall_count=0, rs1_sel=rs2_sel=REG and lock=0 immediately, with no clock edge required.
- ALU chain: issue add x5 then add x6,x5,x5 on the next cycle with advance=1 -> rs1_sel=rs2_sel=ALU. With one independent instruction between them -> EXE. With two between -> MEM. With three between -> REG.
- Load-use: issue lw x7 then add x8,x7,x0 -> lock=1 for exactly 2 cycles, rs1_sel=MEM once lock drops, stall_count=2.
- Priority and x0: issue add x3, add x3, then add x4,x3,x3 -> ALU (youngest). Issue add x0 then add x9,x0,x0 -> REG, lock=0.
- Flush: issue lw x10 with flush=1 in the same cycle, then add x11,x10,x0 -> lock=0, rs1_sel=REG.
- Hold and saturation: with advance=0 for 5 cycles, the slots are unchanged and the selects are stable. With CNT_W=4 and lock held for 20 cycles -> stall_count=15.
